// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I opcode, funct and command-class definitions for the program loader
// and the CPU controller that decodes the same words.
package instr_encoder_loader_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [6:0] F7_ALT = 7'h20;

  typedef enum logic [2:0] {
    CMD_LOAD    = 3'd0,
    CMD_STORE   = 3'd1,
    CMD_BRANCH  = 3'd2,
    CMD_OP      = 3'd3,
    CMD_OP_IMM  = 3'd4,
    CMD_JAL     = 3'd5,
    CMD_JALR    = 3'd6,
    CMD_ILLEGAL = 3'd7
  } cmd_class_e;

  // True when v survives truncation to a w-bit two's-complement field.
  function automatic logic fits_s(input logic [31:0] v, input int w);
    logic signed [31:0] sx;
    sx = $signed(v << (32 - w)) >>> (32 - w);
    return sx == $signed(v);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encode.sv
// Combinational RV32I encoder: command class, register fields and immediate
// to a 32-bit instruction word plus an illegal flag for bad class or immediate.
module rv32i_encode
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [6:0] f7;
  assign f7 = alt_i ? F7_ALT : 7'h00;

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      CMD_LOAD: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD, 2'b11};
        illegal_o = !fits_s(imm_i, 12);
      end
      CMD_STORE: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE, 2'b11};
        illegal_o = !fits_s(imm_i, 12);
      end
      CMD_BRANCH: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], OPC_BRANCH, 2'b11};
        illegal_o = !fits_s(imm_i, 13) || imm_i[0];
      end
      CMD_OP: begin
        word_o = {f7, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP, 2'b11};
      end
      CMD_OP_IMM: begin
        // Shifts carry a 5-bit shamt and reuse the upper field as funct7.
        if (funct3_i == F3_SLL || funct3_i == F3_SR) begin
          word_o    = {f7, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM, 2'b11};
          illegal_o = |imm_i[31:5];
        end else begin
          word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM, 2'b11};
          illegal_o = !fits_s(imm_i, 12);
        end
      end
      CMD_JAL: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL, 2'b11};
        illegal_o = !fits_s(imm_i, 21) || imm_i[0];
      end
      CMD_JALR: begin
        word_o    = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_JALR, 2'b11};
        illegal_o = !fits_s(imm_i, 12);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts structured commands, encodes them to RV32I words and
// writes them to consecutive instruction-memory addresses over a we/ack port.
//
// state | meaning
// IDLE  | ready for a command (unless memory region is full)
// WRITE | encoded word presented, imem_we_o held until imem_ack_i
// FULL  | DEPTH words written, waits for start_i or rst_i
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [2:0]        cmd_funct3_i,
  input  logic              cmd_alt_i,
  input  logic [4:0]        cmd_rd_i,
  input  logic [4:0]        cmd_rs1_i,
  input  logic [4:0]        cmd_rs2_i,
  input  logic [31:0]       cmd_imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_ack_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] BASE_C  = BASE[ADDR_W-1:0];

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d, count_inc;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic [31:0]       enc_word;
  logic              enc_illegal;

  rv32i_encode u_encode (
    .op_i      (cmd_op_i),
    .funct3_i  (cmd_funct3_i),
    .alt_i     (cmd_alt_i),
    .rd_i      (cmd_rd_i),
    .rs1_i     (cmd_rs1_i),
    .rs2_i     (cmd_rs2_i),
    .imm_i     (cmd_imm_i),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign accept    = cmd_valid_i & ready_q;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (start_i) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      addr_d  = BASE_C;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == S_WRITE && imem_ack_i) begin
      we_d    = 1'b0;
      addr_d  = addr_q + 1'b1;
      count_d = count_inc;
      state_d = (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
    end
    // accept implies IDLE, so it can only follow the start_i branch or no branch.
    if (accept) begin
      if (enc_illegal) begin
        err_d = 1'b1;
      end else begin
        wdata_d = enc_word;
        we_d    = 1'b1;
        state_d = S_WRITE;
      end
    end
    ready_d = (state_d == S_IDLE) && (count_d != DEPTH_C);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_C;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready_o  = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign full_o       = (count_q == DEPTH_C);
  assign err_o        = err_q;

endmodule
